transpose_out_ctrl: RTL and testbench

Output-side controller for the matrix transpose unit. It accepts the rotated rows the transpose banks emit, realigns each row with a barrel rotate by the row's shift amount, and tags it with its row index and an end-of-matrix flag. It then buffers rows in a small FIFO so the downstream consumer can apply valid/ready backpressure. The upstream side is valid-only and cannot stall, so the block reports FIFO occupancy and a sticky overflow flag.

---
 rtl/transpose_out_ctrl.sv | 125 ++++++++++++
 tb/tb_transpose_out_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_out_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : transpose_out_ctrl
// Brief   : Realigns rotated transpose rows, tags index/last, buffers in FIFO.
// Rev     : 1.0
//------------------------------------------------------------------------------
module transpose_out_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_PE         = 8,
  parameter int ROW_BITS       = DATA_WIDTH * NUM_PE,
  parameter int SHIFT_AMT_BITS = 9,
  parameter int IDX_BITS       = $clog2(NUM_PE),
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_val,
  input  logic [ROW_BITS-1:0]           in_data,
  input  logic [SHIFT_AMT_BITS-1:0]     in_shift_amt,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [ROW_BITS-1:0]           out_data,
  output logic [IDX_BITS-1:0]           out_row_idx,
  output logic                          out_last,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] C_DEPTH    = CNT_BITS'(FIFO_DEPTH);
  localparam logic [IDX_BITS-1:0] C_LAST_IDX = IDX_BITS'(NUM_PE - 1);

  logic [IDX_BITS-1:0]  r_row_cnt;
  logic                 r_stage_val;
  logic [ROW_BITS-1:0]  r_stage_data;
  logic [IDX_BITS-1:0]  r_stage_idx;
  logic                 r_stage_last;

  logic [ROW_BITS-1:0]  r_mem_data [FIFO_DEPTH];
  logic [IDX_BITS-1:0]  r_mem_idx  [FIFO_DEPTH];
  logic                 r_mem_last [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  r_head;
  logic [PTR_BITS-1:0]  r_tail;
  logic [CNT_BITS-1:0]  r_count;
  logic                 r_overflow;

  logic [31:0]          w_sh;
  logic [31:0]          w_lsh;
  logic [ROW_BITS-1:0]  w_aligned;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  // Right rotate; a zero shift makes the left term shift out completely.
  assign w_sh      = 32'(in_shift_amt) % 32'(ROW_BITS);
  assign w_lsh     = 32'(ROW_BITS) - w_sh;
  assign w_aligned = (in_data >> w_sh) | (in_data << w_lsh);

  assign out_val  = (r_count != '0);
  assign full     = (r_count == C_DEPTH);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign out_data    = r_mem_data[r_head];
  assign out_row_idx = r_mem_idx[r_head];
  assign out_last    = r_mem_last[r_head];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_pop  = out_val && out_rdy;
  assign w_push = r_stage_val && (!full || w_pop);
  assign w_drop = r_stage_val && full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_cnt    <= '0;
      r_stage_val  <= 1'b0;
      r_stage_data <= '0;
      r_stage_idx  <= '0;
      r_stage_last <= 1'b0;
    end else begin
      r_stage_val <= in_val;
      if (in_val) begin
        r_stage_data <= w_aligned;
        r_stage_idx  <= r_row_cnt;
        r_stage_last <= (r_row_cnt == C_LAST_IDX);
        r_row_cnt    <= (r_row_cnt == C_LAST_IDX) ? '0 : r_row_cnt + IDX_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
        r_mem_last[i] <= 1'b0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_data[r_tail] <= r_stage_data;
        r_mem_idx[r_tail]  <= r_stage_idx;
        r_mem_last[r_tail] <= r_stage_last;
        r_tail             <= r_tail + PTR_BITS'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_BITS'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_BITS'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_BITS'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transpose_out_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_transpose_out_ctrl
// Brief   : Directed self-checking bench for transpose_out_ctrl.
// Rev     : 1.0
//------------------------------------------------------------------------------
module tb_transpose_out_ctrl;

  localparam int DW   = 64;
  localparam int NPE  = 8;
  localparam int RB   = DW * NPE;
  localparam int SB   = 9;
  localparam int IB   = 3;
  localparam int DEP  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_val = 1'b0;
  logic [RB-1:0]  in_data = '0;
  logic [SB-1:0]  in_shift_amt = '0;
  logic           out_val;
  logic           out_rdy = 1'b0;
  logic [RB-1:0]  out_data;
  logic [IB-1:0]  out_row_idx;
  logic           out_last;
  logic           full;
  logic [2:0]     count;
  logic           overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  transpose_out_ctrl #(
    .DATA_WIDTH(DW), .NUM_PE(NPE), .ROW_BITS(RB), .SHIFT_AMT_BITS(SB),
    .IDX_BITS(IB), .FIFO_DEPTH(DEP)
  ) u_dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_data(in_data),
    .in_shift_amt(in_shift_amt), .out_val(out_val), .out_rdy(out_rdy),
    .out_data(out_data), .out_row_idx(out_row_idx), .out_last(out_last),
    .full(full), .count(count), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_val = 1'b0;
    out_rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [RB-1:0] make_row(input int base);
    logic [RB-1:0] r;
    r = '0;
    for (int j = 0; j < NPE; j++) r[j*DW +: DW] = DW'(base + j);
    return r;
  endfunction

  function automatic logic [RB-1:0] rotl(input logic [RB-1:0] r, input int n);
    logic [RB-1:0] o;
    o = '0;
    for (int k = 0; k < RB; k++) o[(k + n) % RB] = r[k];
    return o;
  endfunction

  initial begin
    logic [RB-1:0] v;

    // Reset state
    step();
    check("rst_out_val",  out_val,     0);
    check("rst_count",    count,       0);
    check("rst_full",     full,        0);
    check("rst_overflow", overflow,    0);
    check("rst_out_data", out_data,    0);
    check("rst_idx",      out_row_idx, 0);
    check("rst_last",     out_last,    0);
    do_reset();

    // Single row, shift 0
    out_rdy = 1'b1;
    in_val = 1'b1; in_data = make_row(0); in_shift_amt = '0;
    step();
    in_val = 1'b0;
    check("single_t1_val", out_val, 0);
    step();
    check("single_val",  out_val,     1);
    check("single_data", out_data,    make_row(0));
    check("single_idx",  out_row_idx, 0);
    check("single_last", out_last,    0);
    step();
    check("single_count", count,   0);
    check("single_empty", out_val, 0);

    // Full matrix plus a 9th row that wraps the index
    do_reset();
    out_rdy = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      if (n - 1 < 9) begin
        in_val = 1'b1;
        in_shift_amt = SB'(((n - 1) % NPE) * DW);
        in_data = rotl(make_row(16 * (n - 1)), ((n - 1) % NPE) * DW);
      end else begin
        in_val = 1'b0;
      end
      step();
      if (n >= 2 && n - 2 < 9) begin
        check("mat_val",  out_val,     1);
        check("mat_data", out_data,    make_row(16 * (n - 2)));
        check("mat_idx",  out_row_idx, RB'((n - 2) % NPE));
        check("mat_last", out_last,    RB'((n - 2) == 7));
      end
    end
    check("mat_drained", out_val, 0);

    // Rotation edge: word 7 moves to word 0
    do_reset();
    out_rdy = 1'b1;
    v = '0;
    v[7*DW +: DW] = 64'hA5;
    in_val = 1'b1; in_data = v; in_shift_amt = 9'd448;
    step();
    in_val = 1'b0;
    step();
    v = '0;
    v[0 +: DW] = 64'hA5;
    check("rot_val",  out_val,  1);
    check("rot_data", out_data, v);

    // Backpressure and overflow
    do_reset();
    out_rdy = 1'b0;
    in_shift_amt = '0;
    for (int n = 1; n <= 6; n++) begin
      if (n <= 5) begin
        in_val = 1'b1; in_data = make_row(256 * n);
      end else begin
        in_val = 1'b0;
      end
      step();
      if (n == 4) check("bp_notfull_yet", full, 0);
      if (n == 5) begin
        check("bp_full",        full,     1);
        check("bp_count4",      count,    4);
        check("bp_no_ovf_yet",  overflow, 0);
      end
    end
    check("bp_overflow",  overflow, 1);
    check("bp_count_hold", count,   4);
    step();
    check("bp_hold_data", out_data,    make_row(256));
    check("bp_hold_idx",  out_row_idx, 0);
    out_rdy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      check("bp_val",  out_val,     1);
      check("bp_idx",  out_row_idx, RB'(r));
      check("bp_data", out_data,    make_row(256 * (r + 1)));
      step();
    end
    check("bp_empty",      out_val,  0);
    check("bp_ovf_sticky", overflow, 1);

    // Full with simultaneous pop: no drop, count pinned at depth
    do_reset();
    for (int n = 1; n <= 15; n++) begin
      if (n - 1 < 10) begin
        in_val = 1'b1; in_data = make_row(512 + 16 * (n - 1));
      end else begin
        in_val = 1'b0;
      end
      out_rdy = (n >= 6);
      if (n >= 6) begin
        check("sp_val",  out_val,     1);
        check("sp_data", out_data,    make_row(512 + 16 * (n - 6)));
        check("sp_idx",  out_row_idx, RB'((n - 6) % NPE));
      end
      step();
      if (n >= 5 && n <= 11) check("sp_count4", count, 4);
    end
    check("sp_no_ovf", overflow, 0);
    check("sp_empty",  out_val,  0);

    // Reset mid-stream
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      in_val = 1'b1; in_data = make_row(1024 + 16 * n);
      step();
    end
    check("mr_count3", count, 3);
    rst = 1'b1;
    #1;
    check("mr_val",   out_val,  0);
    check("mr_count", count,    0);
    check("mr_ovf",   overflow, 0);
    step();
    in_val = 1'b0;
    step();
    rst = 1'b0;
    out_rdy = 1'b1;
    in_val = 1'b1; in_data = make_row(2048);
    step();
    in_val = 1'b0;
    step();
    check("mr_post_val",  out_val,     1);
    check("mr_post_idx",  out_row_idx, 0);
    check("mr_post_data", out_data,    make_row(2048));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
